bsg_activation_mac: RTL and testbench
=====================================

// Module: bsg_activation_mac
// PURPOSE
//  Upstream feeder for bsg_activation: streaming signed multiply-accumulate
//  (dot product + bias) for one neuron. Consumes (x, w) pairs one per cycle,
//  then saturates the sum into the activation angle format (signed,
//  ang_width_p bits, frac_p fractional bits). Presents the result with
//  valid/ready, along with the tanh/sigmoid select captured for that vector.
// PARAMETERS
//  in_width_p   16  width of x_i/w_i; signed, in_frac_p fractional bits
//  in_frac_p    8   fractional bits of x_i/w_i; product has 2*in_frac_p = frac_p
//  frac_p       16  fractional bits of bias_i, accumulator and ang_o
//  ang_width_p  21  output angle width (signed, matches activation ang_i)
//  acc_width_p  40  accumulator width (signed); >= 2*in_width_p+clog2(max_len_p)
//  max_len_p    64  maximum elements per vector
// PORTS
//  clk_i       in   1            clock, rising edge
//  reset_n_i   in   1            asynchronous active-low reset
//  v_i         in   1            x_i/w_i/last_i (and bias_i/tanh_sel_i on first beat) valid
//  ready_o     out  1            element accepted when v_i & ready_o
//  x_i         in   in_width_p   input activation element
//  w_i         in   in_width_p   weight element
//  bias_i      in   ang_width_p  bias, sampled on first beat of a vector only
//  tanh_sel_i  in   1            function select, sampled on first beat only
//  last_i      in   1            final element of vector
//  v_o         out  1            result valid
//  ready_i     in   1            downstream ready; result leaves on v_o & ready_i
//  ang_o       out  ang_width_p  saturated sum, held stable while v_o & ~ready_i
//  tanh_sel_o  out  1            captured function select for this result
//  sat_o       out  1            sum was clipped to ang_width_p range
//  len_err_o   out  1            vector hit max_len_p without last_i
// BEHAVIOUR
//  Reset (async assert, sync deassert in parent): state=e_ACC, acc=0, cnt=0,
//   prod_v=0, v_o=0, ang_o=0, tanh_sel_o=0, sat_o=0, len_err_o=0.
//  States: e_ACC -> e_DRAIN -> e_OUT -> e_ACC.
//   e_ACC: ready_o=1. Accept -> prod_r<=x_i*w_i (signed, 2*in_width_p), prod_v<=1.
//    First beat (cnt==0): acc <= sext(bias_i) (+prod_r of any prior beat is
//    impossible, prod_v=0 at cnt==0); latch tanh_sel_i. cnt++ per accept.
//    Accept with last_i, or with cnt==max_len_p-1 -> e_DRAIN; latter sets len_err.
//   e_DRAIN: ready_o=0; adds final prod_r, computes saturation -> e_OUT.
//   e_OUT: ready_o=0, v_o=1; on ready_i -> e_ACC, cnt=0, acc cleared.
//  Pipeline: prod_v pending product is added to acc each cycle (sext to acc).
//  Latency: last beat accepted in cycle N -> v_o high in cycle N+2.
//  Throughput: one element/cycle; two dead cycles per vector (DRAIN+handoff).
//  Saturation: if acc > 2^(ang_width_p-1)-1 -> max, sat_o=1; if
//   acc < -2^(ang_width_p-1) -> min, sat_o=1; else acc[ang_width_p-1:0].
//  Outputs ang_o/tanh_sel_o/sat_o/len_err_o are registered, change only on
//   entry to e_OUT; they hold value after handoff until next result.
//  v_i while ready_o=0 is ignored (no buffering). last_i ignored unless v_i.
//  Single-element vector (first beat also last) is legal.
//  Reset mid-vector discards partial sum; no output produced for it.
//  acc never wraps given acc_width_p rule; no internal overflow detection.
// STRUCTURE
//  Shared package bsg_activation_pkg: state enum {e_ACC,e_DRAIN,e_OUT},
//   fixed-point constants (frac_p=16, one = 1<<frac_p, ang_width_p default),
//   also used by bsg_activation's threshold/one constants.
//  One sub-module: bsg_activation_sat (combinational signed clip
//   acc_width_p -> ang_width_p, outputs value and sat flag).
// TESTING (in_frac_p=8, frac_p=16, ang_width_p=21)
//  1 elem x=0x0180(1.5) w=0x0200(2.0) bias=0 last -> ang_o=0x30000, v_o at N+2.
//  x=0xFF00(-1.0) w=0x0080(0.5) bias=0x04000(0.25) last -> ang_o=0x1FC000, sat_o=0.
//  x=0x7F00 w=0x7F00 last -> ang_o=0x0FFFFF, sat_o=1; negate w -> 0x100000, sat_o=1.
//  4 elems x=w=0x0100 back-to-back, then ready_i low 5 cycles -> ang_o=0x40000
//   stable, ready_o=0 throughout, handoff on ready_i, next vector accepted N+1.
//  max_len_p=4, 4 beats no last -> result after 4th, len_err_o=1; 5th beat waits.
//  reset_n_i low mid-vector (2 of 4 beats) -> all outputs 0 same cycle; fresh
//   vector after release gives correct sum with no residue.

Source files
------------

// File: rtl/bsg_activation_pkg.sv
// rtl/bsg_activation_pkg.sv - shared fixed-point constants and MAC state encoding
package bsg_activation_pkg;

    localparam int act_frac_lp      = 16;
    localparam int act_ang_width_lp = 21;
    localparam logic [act_ang_width_lp-1:0] act_one_lp = act_ang_width_lp'(1) << act_frac_lp;

    typedef enum logic [1:0] {
        e_ACC,
        e_DRAIN,
        e_OUT
    } mac_state_e;

endpackage

// File: rtl/bsg_activation_sat.sv
// rtl/bsg_activation_sat.sv - combinational signed clip from accumulator to angle width
module bsg_activation_sat #(
    parameter int acc_width_p = 40,
    parameter int ang_width_p = 21
) (
    input  logic signed [acc_width_p-1:0] acc_i,
    output logic        [ang_width_p-1:0] ang_o,
    output logic                          sat_o
);

    // The value fits only when every bit from the MSB down to the output sign bit agrees.
    logic [acc_width_p-ang_width_p:0] upper;

    assign upper = acc_i[acc_width_p-1:ang_width_p-1];
    assign sat_o = ~((&upper) | ~(|upper));

    always_comb begin
        ang_o = acc_i[ang_width_p-1:0];
        if (sat_o) begin
            ang_o = acc_i[acc_width_p-1] ? {1'b1, {(ang_width_p-1){1'b0}}}
                                         : {1'b0, {(ang_width_p-1){1'b1}}};
        end
    end

endmodule

// File: rtl/bsg_activation_mac.sv
// rtl/bsg_activation_mac.sv - streaming signed dot product plus bias, saturated to angle format
module bsg_activation_mac
    import bsg_activation_pkg::*;
#(
    parameter int in_width_p  = 16,
    parameter int in_frac_p   = 8,
    parameter int frac_p      = act_frac_lp,
    parameter int ang_width_p = act_ang_width_lp,
    parameter int acc_width_p = 40,
    parameter int max_len_p   = 64
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          v_i,
    output logic                          ready_o,
    input  logic signed [in_width_p-1:0]  x_i,
    input  logic signed [in_width_p-1:0]  w_i,
    input  logic signed [ang_width_p-1:0] bias_i,
    input  logic                          tanh_sel_i,
    input  logic                          last_i,
    output logic                          v_o,
    input  logic                          ready_i,
    output logic        [ang_width_p-1:0] ang_o,
    output logic                          tanh_sel_o,
    output logic                          sat_o,
    output logic                          len_err_o
);

    localparam int cnt_w_lp      = $clog2(max_len_p + 1);
    localparam int prod_w_lp     = 2 * in_width_p;
    localparam int prod_shift_lp = frac_p - 2 * in_frac_p;

    mac_state_e                     state_q, state_d;
    logic signed [acc_width_p-1:0]  acc_q, acc_d;
    logic        [cnt_w_lp-1:0]     cnt_q, cnt_d;
    logic signed [prod_w_lp-1:0]    prod_q, prod_d;
    logic                           prod_v_q, prod_v_d;
    logic                           tsel_q, tsel_d;
    logic                           lerr_q, lerr_d;
    logic                           v_o_q, v_o_d;
    logic        [ang_width_p-1:0]  ang_q, ang_d;
    logic                           tanh_sel_q, tanh_sel_d;
    logic                           sat_q, sat_d;
    logic                           len_err_q, len_err_d;

    logic                           accept;
    logic                           at_max;
    logic signed [acc_width_p-1:0]  prod_ext;
    logic signed [acc_width_p-1:0]  acc_sum;
    logic        [ang_width_p-1:0]  clip_val;
    logic                           clip_sat;

    assign ready_o  = (state_q == e_ACC);
    assign accept   = v_i & ready_o;
    assign at_max   = (cnt_q == cnt_w_lp'(max_len_p - 1));
    assign prod_ext = acc_width_p'(prod_q) <<< prod_shift_lp;
    assign acc_sum  = acc_q + (prod_v_q ? prod_ext : '0);

    bsg_activation_sat #(
        .acc_width_p(acc_width_p),
        .ang_width_p(ang_width_p)
    ) u_sat (
        .acc_i(acc_sum),
        .ang_o(clip_val),
        .sat_o(clip_sat)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        prod_d     = prod_q;
        prod_v_d   = prod_v_q;
        tsel_d     = tsel_q;
        lerr_d     = lerr_q;
        v_o_d      = v_o_q;
        ang_d      = ang_q;
        tanh_sel_d = tanh_sel_q;
        sat_d      = sat_q;
        len_err_d  = len_err_q;

        case (state_q)
            e_ACC: begin
                acc_d    = acc_sum;
                prod_v_d = 1'b0;
                if (accept) begin
                    prod_d   = prod_w_lp'(x_i) * prod_w_lp'(w_i);
                    prod_v_d = 1'b1;
                    cnt_d    = cnt_q + cnt_w_lp'(1);
                    // No product is ever pending on the first beat, so the bias simply seeds the sum.
                    if (cnt_q == '0) begin
                        acc_d  = acc_width_p'(bias_i);
                        tsel_d = tanh_sel_i;
                        lerr_d = 1'b0;
                    end
                    if (last_i || at_max) begin
                        state_d = e_DRAIN;
                        lerr_d  = ~last_i;
                    end
                end
            end
            e_DRAIN: begin
                acc_d      = acc_sum;
                prod_v_d   = 1'b0;
                ang_d      = clip_val;
                sat_d      = clip_sat;
                tanh_sel_d = tsel_q;
                len_err_d  = lerr_q;
                v_o_d      = 1'b1;
                state_d    = e_OUT;
            end
            e_OUT: begin
                if (ready_i) begin
                    v_o_d   = 1'b0;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = e_ACC;
                end
            end
            default: begin
                state_d = e_ACC;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= e_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            prod_q     <= '0;
            prod_v_q   <= 1'b0;
            tsel_q     <= 1'b0;
            lerr_q     <= 1'b0;
            v_o_q      <= 1'b0;
            ang_q      <= '0;
            tanh_sel_q <= 1'b0;
            sat_q      <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            prod_v_q   <= prod_v_d;
            tsel_q     <= tsel_d;
            lerr_q     <= lerr_d;
            v_o_q      <= v_o_d;
            ang_q      <= ang_d;
            tanh_sel_q <= tanh_sel_d;
            sat_q      <= sat_d;
            len_err_q  <= len_err_d;
        end
    end

    assign v_o        = v_o_q;
    assign ang_o      = ang_q;
    assign tanh_sel_o = tanh_sel_q;
    assign sat_o      = sat_q;
    assign len_err_o  = len_err_q;

endmodule

// File: tb/tb_bsg_activation_mac.sv
// tb/tb_bsg_activation_mac.sv - directed and randomized checks of bsg_activation_mac
module tb_bsg_activation_mac;

    localparam int max_len_lp = 4;

    logic               clk = 1'b0;
    logic               reset_n_i;
    logic               v_i;
    logic               ready_o;
    logic signed [15:0] x_i;
    logic signed [15:0] w_i;
    logic signed [20:0] bias_i;
    logic               tanh_sel_i;
    logic               last_i;
    logic               v_o;
    logic               ready_i;
    logic        [20:0] ang_o;
    logic               tanh_sel_o;
    logic               sat_o;
    logic               len_err_o;

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] xs [max_len_lp];
    logic signed [15:0] ws [max_len_lp];
    logic signed [20:0] bias_v;
    logic               tsel_v;

    always #5 clk = ~clk;

    bsg_activation_mac #(.max_len_p(max_len_lp)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .ready_o(ready_o),
        .x_i(x_i), .w_i(w_i), .bias_i(bias_i), .tanh_sel_i(tanh_sel_i),
        .last_i(last_i), .v_o(v_o), .ready_i(ready_i), .ang_o(ang_o),
        .tanh_sel_o(tanh_sel_o), .sat_o(sat_o), .len_err_o(len_err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a falling edge; sends n beats, then checks the result and handoff.
    task automatic run_vec(input string tag, input int n, input bit use_last, input int hold);
        longint      s;
        logic [20:0] exp_ang;
        logic        exp_sat;
        int          k;
        s = longint'(bias_v);
        for (int i = 0; i < n; i++) s += longint'(xs[i]) * longint'(ws[i]);
        if (s > 64'sd1048575) begin
            exp_ang = 21'h0FFFFF; exp_sat = 1'b1;
        end else if (s < -64'sd1048576) begin
            exp_ang = 21'h100000; exp_sat = 1'b1;
        end else begin
            exp_ang = s[20:0]; exp_sat = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            v_i        = 1'b1;
            x_i        = xs[i];
            w_i        = ws[i];
            last_i     = use_last && (i == n - 1);
            bias_i     = (i == 0) ? bias_v : 21'($urandom);
            tanh_sel_i = (i == 0) ? tsel_v : 1'($urandom);
            k = 0;
            while (!ready_o && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk({tag, ".ready_acc"}, 64'(ready_o), 64'd1);
            @(negedge clk);
        end
        // Junk beats during drain/output must be ignored.
        v_i = 1'b1; x_i = 16'h7FFF; w_i = 16'h7FFF; last_i = 1'b1;
        chk({tag, ".drain_v"}, 64'(v_o), 64'd0);
        chk({tag, ".drain_ready"}, 64'(ready_o), 64'd0);
        @(negedge clk);
        chk({tag, ".v_n2"}, 64'(v_o), 64'd1);
        chk({tag, ".ang"}, 64'(ang_o), 64'(exp_ang));
        chk({tag, ".sat"}, 64'(sat_o), 64'(exp_sat));
        chk({tag, ".tsel"}, 64'(tanh_sel_o), 64'(tsel_v));
        chk({tag, ".len_err"}, 64'(len_err_o), 64'(!use_last));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_v"}, 64'(v_o), 64'd1);
            chk({tag, ".hold_ang"}, 64'(ang_o), 64'(exp_ang));
            chk({tag, ".hold_ready"}, 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        v_i     = 1'b0;
        last_i  = 1'b0;
        chk({tag, ".post_v"}, 64'(v_o), 64'd0);
        chk({tag, ".post_ang"}, 64'(ang_o), 64'(exp_ang));
        chk({tag, ".post_ready"}, 64'(ready_o), 64'd1);
    endtask

    task automatic fill(input int i, input logic [15:0] x, input logic [15:0] w);
        xs[i] = x;
        ws[i] = w;
    endtask

    initial begin
        reset_n_i = 1'b0; v_i = 1'b0; x_i = '0; w_i = '0; bias_i = '0;
        tanh_sel_i = 1'b0; last_i = 1'b0; ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.v_o", 64'(v_o), 64'd0);
        chk("rst.ang", 64'(ang_o), 64'd0);
        chk("rst.sat", 64'(sat_o), 64'd0);
        chk("rst.len_err", 64'(len_err_o), 64'd0);
        chk("rst.tsel", 64'(tanh_sel_o), 64'd0);
        reset_n_i = 1'b1;
        @(negedge clk);

        fill(0, 16'h0180, 16'h0200); bias_v = 21'h0; tsel_v = 1'b1;
        run_vec("one_elem", 1, 1'b1, 0);
        chk("one_elem.ang_const", 64'(ang_o), 64'h30000);

        fill(0, 16'hFF00, 16'h0080); bias_v = 21'h04000; tsel_v = 1'b0;
        run_vec("neg_bias", 1, 1'b1, 1);
        chk("neg_bias.ang_const", 64'(ang_o), 64'h1FC000);

        fill(0, 16'h7F00, 16'h7F00); bias_v = 21'h0; tsel_v = 1'b1;
        run_vec("sat_pos", 1, 1'b1, 0);
        chk("sat_pos.ang_const", 64'(ang_o), 64'h0FFFFF);

        fill(0, 16'h7F00, 16'h8100); bias_v = 21'h0; tsel_v = 1'b0;
        run_vec("sat_neg", 1, 1'b1, 0);
        chk("sat_neg.ang_const", 64'(ang_o), 64'h100000);

        for (int i = 0; i < 4; i++) fill(i, 16'h0100, 16'h0100);
        bias_v = 21'h0; tsel_v = 1'b1;
        run_vec("four_hold", 4, 1'b1, 5);
        chk("four_hold.ang_const", 64'(ang_o), 64'h40000);
        run_vec("b2b", 4, 1'b1, 0);

        for (int i = 0; i < 4; i++) fill(i, 16'h0080, 16'h0100);
        bias_v = 21'h1; tsel_v = 1'b1;
        run_vec("len_err", 4, 1'b0, 2);

        // Partial vector killed by reset, then a clean vector must carry no residue.
        for (int i = 0; i < 2; i++) begin
            v_i = 1'b1; x_i = 16'h0700; w_i = 16'h0300; last_i = 1'b0;
            bias_i = 21'h00100; tanh_sel_i = 1'b1;
            @(negedge clk);
        end
        v_i = 1'b0;
        reset_n_i = 1'b0;
        #1;
        chk("midrst.v_o", 64'(v_o), 64'd0);
        chk("midrst.ang", 64'(ang_o), 64'd0);
        chk("midrst.tsel", 64'(tanh_sel_o), 64'd0);
        chk("midrst.len_err", 64'(len_err_o), 64'd0);
        chk("midrst.sat", 64'(sat_o), 64'd0);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        fill(0, 16'h0100, 16'h0300); fill(1, 16'h0200, 16'hFF00);
        bias_v = 21'h08000; tsel_v = 1'b0;
        run_vec("after_rst", 2, 1'b1, 0);

        for (int t = 0; t < 24; t++) begin
            int  n;
            bit  use_last;
            n = $urandom_range(1, max_len_lp);
            for (int i = 0; i < max_len_lp; i++) begin
                if (t % 3 == 0) fill(i, 16'($urandom), 16'($urandom));
                else fill(i, 16'(int'($urandom_range(0, 1023)) - 512),
                             16'(int'($urandom_range(0, 1023)) - 512));
            end
            bias_v   = 21'($urandom);
            tsel_v   = 1'($urandom);
            use_last = !(n == max_len_lp && ($urandom_range(0, 3) == 0));
            run_vec($sformatf("rand%0d", t), n, use_last, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
